dmem_arbiter: RTL and testbench

Two-port arbiter placed in front of `DataMemory`. It shares the single memory port between the CPU MEM stage and a DMA/program-loader port. CPU requests have fixed priority, and a starvation counter bounds how long DMA can wait. The block tracks the memory's 1-cycle registered read latency and routes each returned word only to the requester that issued the read. DMA access to the MMIO window is filtered out.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: address/data widths, load/store funct3
// codes, and the data-memory arbiter's state and owner encodings.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ALEN = 32;

  // Load/store width encodings carried on funct3.
  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  // Start of the memory-mapped I/O window (LEDs and other peripherals).
  localparam logic [ALEN-1:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    ARB_CPU = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

  // Which requester owns the read currently returning from memory.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the CPU MEM stage and a DMA /
// program-loader port. CPU has fixed priority; a starvation counter hands
// DMA one forced grant after MAX_WAIT consecutive denials. Read data from
// the 1-cycle registered memory is routed back only to the port that issued
// the read. DMA accesses into the MMIO window are accepted but suppressed.
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned     MAX_WAIT  = 4,
  parameter logic [ALEN-1:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
  input  logic            clk,
  input  logic            rst_n,
  // CPU MEM-stage port
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [3:0]      cpu_be,
  input  logic [2:0]      cpu_funct3,
  input  logic [ALEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [XLEN-1:0] cpu_rdata,
  // DMA / loader port
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [3:0]      dma_be,
  input  logic [2:0]      dma_funct3,
  input  logic [ALEN-1:0] dma_addr,
  input  logic [XLEN-1:0] dma_wdata,
  output logic            dma_gnt,
  output logic            dma_rvalid,
  output logic [XLEN-1:0] dma_rdata,
  output logic            dma_err,
  // DataMemory port
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_t state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       rd_pend;
  arb_owner_t rd_owner;
  logic       rd_zero;
  logic       dma_err_q;
  logic       dma_mmio;

  assign dma_mmio = (dma_addr >= MMIO_BASE);

  // Grant decision: a lone requester always wins; on conflict the FSM state
  // picks. Nothing is granted while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case leaves it unassigned and infers a latch.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (rst_n) begin
      if (cpu_req && dma_req) begin
        if (state == ARB_DMA) dma_gnt = 1'b1;
        else                  cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end
  end

  // Memory-port mux; a filtered DMA access is presented with writes blocked.
  always_comb begin
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_funct3 = rst_n ? F3_WORD : 3'b000;
    if (cpu_gnt) begin
      mem_we     = cpu_we;
      mem_be     = cpu_be;
      mem_funct3 = cpu_funct3;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we     = dma_we && !dma_mmio;
      mem_be     = dma_be;
      mem_funct3 = dma_funct3;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
    end
  end

  // Starvation counter and priority FSM next-state.
  always_comb begin
    wait_nxt  = wait_cnt;
    state_nxt = state;
    if (!dma_req || dma_gnt)       wait_nxt = 4'd0;
    else if (wait_cnt < MAX_WAIT_C) wait_nxt = wait_cnt + 4'd1;
    case (state)
      ARB_CPU: if (wait_nxt == MAX_WAIT_C) state_nxt = ARB_DMA;
      ARB_DMA: if (dma_gnt || !dma_req)    state_nxt = ARB_CPU;
      default: state_nxt = ARB_CPU;
    endcase
  end

  // FSM, starvation counter and read-return tracking registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= ARB_CPU;
      wait_cnt  <= 4'd0;
      rd_pend   <= 1'b0;
      rd_owner  <= OWN_CPU;
      rd_zero   <= 1'b0;
      dma_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      rd_pend   <= (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
      rd_owner  <= dma_gnt ? OWN_DMA : OWN_CPU;
      rd_zero   <= dma_gnt && !dma_we && dma_mmio;
      dma_err_q <= dma_gnt && dma_mmio;
    end
  end

  // Read return routing. Gating with rst_n drops a read that was in flight
  // when reset arrived, and keeps every output low during reset.
  assign cpu_rvalid = rst_n && rd_pend && (rd_owner == OWN_CPU);
  assign dma_rvalid = rst_n && rd_pend && (rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = (dma_rvalid && !rd_zero) ? mem_rdata : '0;
  assign dma_err    = rst_n && dma_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// random two-port traffic, all checked against a transaction-level model
// (priority by denial streak, byte-addressed memory image, 1-cycle returns).
module tb_dmem_arbiter;
  import riscv_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam logic [31:0] MMIO     = 32'h8000_0000;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [3:0]  cpu_be;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid, dma_err;
  logic [3:0]  dma_be;
  logic [2:0]  dma_funct3;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_funct3(dma_funct3),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      F3_BYTE:  return {{24{s[7]}}, s[7:0]};
      F3_HALF:  return {{16{s[15]}}, s[15:0]};
      F3_BYTEU: return {24'd0, s[7:0]};
      F3_HALFU: return {16'd0, s[15:0]};
      default:  return w;
    endcase
  endfunction

  // Stand-in for DataMemory: registered read, byte-enabled write, LED register
  // at the base of the MMIO window.
  logic [31:0] dm [0:255] = '{default: 32'd0};
  logic [31:0] leds = 32'd0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr == MMIO) leds <= merge(leds, mem_wdata, mem_be);
      else dm[mem_addr[9:2]] <= merge(dm[mem_addr[9:2]], mem_wdata, mem_be);
    end
    mem_rdata <= ext_load(dm[mem_addr[9:2]], mem_addr[1:0], mem_funct3);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  int          streak = 0;       // consecutive cycles DMA asked and was refused
  logic        exp_crv = 0, exp_drv = 0;
  logic [31:0] exp_crd = 0, exp_drd = 0;
  logic        exp_err = 0;
  logic        eg_c = 0, eg_d = 0;
  logic        obs_cg, obs_dg, obs_crv, obs_drv, obs_err, obs_mwe;
  logic [31:0] obs_crd, obs_drd;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    return ref_mem.exists(k) ? ref_mem[k] : 32'd0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ref_mem[a >> 2] = merge(ref_rd(a), d, be);
  endtask

  // One clock: sample and check at negedge, advance the model, then return
  // just after the next rising edge so the caller can drive new inputs.
  task automatic step();
    logic        d_mmio, n_crv, n_drv, n_err;
    logic [31:0] n_crd, n_drd, e_addr;
    logic        e_we;
    logic [2:0]  e_f3;
    @(negedge clk);
    d_mmio = (dma_addr >= MMIO);
    eg_c = 1'b0;
    eg_d = 1'b0;
    if (rst_n) begin
      if (dma_req && (!cpu_req || streak >= MAX_WAIT)) eg_d = 1'b1;
      else if (cpu_req)                                eg_c = 1'b1;
    end
    e_we = 1'b0; e_addr = 32'd0; e_f3 = rst_n ? F3_WORD : 3'b000;
    if (eg_c)      begin e_we = cpu_we;            e_addr = cpu_addr; e_f3 = cpu_funct3; end
    else if (eg_d) begin e_we = dma_we && !d_mmio; e_addr = dma_addr; e_f3 = dma_funct3; end

    obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_mwe = mem_we;
    obs_crv = cpu_rvalid; obs_crd = cpu_rdata;
    obs_drv = dma_rvalid; obs_drd = dma_rdata; obs_err = dma_err;

    check("cpu_gnt",    cpu_gnt,    eg_c);
    check("dma_gnt",    dma_gnt,    eg_d);
    check("mem_we",     mem_we,     e_we);
    check("mem_addr",   mem_addr,   e_addr);
    check("mem_funct3", mem_funct3, e_f3);
    check("cpu_rvalid", cpu_rvalid, exp_crv && rst_n);
    check("cpu_rdata",  cpu_rdata,  (exp_crv && rst_n) ? exp_crd : 32'd0);
    check("dma_rvalid", dma_rvalid, exp_drv && rst_n);
    check("dma_rdata",  dma_rdata,  (exp_drv && rst_n) ? exp_drd : 32'd0);
    check("dma_err",    dma_err,    exp_err && rst_n);

    n_crv = 0; n_drv = 0; n_crd = 0; n_drd = 0; n_err = 0;
    if (eg_c) begin
      if (cpu_we) ref_wr(cpu_addr, cpu_wdata, cpu_be);
      else begin n_crv = 1; n_crd = ext_load(ref_rd(cpu_addr), cpu_addr[1:0], cpu_funct3); end
    end
    if (eg_d) begin
      n_err = d_mmio;
      if (dma_we) begin
        if (!d_mmio) ref_wr(dma_addr, dma_wdata, dma_be);
      end else begin
        n_drv = 1;
        n_drd = d_mmio ? 32'd0 : ext_load(ref_rd(dma_addr), dma_addr[1:0], dma_funct3);
      end
    end
    if (!rst_n || !dma_req || eg_d) streak = 0;
    else                            streak++;
    exp_crv = n_crv; exp_crd = n_crd;
    exp_drv = n_drv; exp_drd = n_drd; exp_err = n_err;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [3:0] be,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    cpu_req = req; cpu_we = we; cpu_be = be; cpu_funct3 = f3; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [3:0] be,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    dma_req = req; dma_we = we; dma_be = be; dma_funct3 = f3; dma_addr = a; dma_wdata = d;
  endtask

  task automatic idle();
    cpu_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
    dma_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    cpu_drive(1, 0, 4'hF, F3_WORD, 32'h100, 32'd0);
    dma_drive(1, 0, 4'hF, F3_WORD, 32'h104, 32'd0);

    // Reset held with both requests high: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_cpu_gnt", obs_cg, 1'b0);
      check("rst_dma_gnt", obs_dg, 1'b0);
    end
    rst_n = 1'b1;

    // Continuous contention: CPU 4, DMA 1, repeating; CPU first out of reset.
    for (int k = 0; k < 15; k++) begin
      step();
      check("prio_cpu", obs_cg, (k % 5) != 4);
      check("prio_dma", obs_dg, (k % 5) == 4);
    end
    idle();
    step();
    step();

    // Routing: preload two words, then back-to-back reads from opposite ports.
    cpu_drive(1, 1, 4'hF, F3_WORD, 32'h100, 32'hDEAD_BEEF); step();
    cpu_drive(1, 1, 4'hF, F3_WORD, 32'h104, 32'h1234_5678); step();
    cpu_drive(1, 0, 4'hF, F3_WORD, 32'h100, 32'd0);         step();
    cpu_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
    dma_drive(1, 0, 4'hF, F3_WORD, 32'h104, 32'd0);         step();
    check("route_cpu_rv", obs_crv, 1'b1);
    check("route_cpu_rd", obs_crd, 32'hDEAD_BEEF);
    check("route_dma_rv_quiet", obs_drv, 1'b0);
    idle(); step();
    check("route_dma_rv", obs_drv, 1'b1);
    check("route_dma_rd", obs_drd, 32'h1234_5678);
    check("route_cpu_rv_quiet", obs_crv, 1'b0);

    // MMIO filter: DMA store to the LEDs is swallowed, CPU store lands.
    dma_drive(1, 1, 4'hF, F3_WORD, MMIO, 32'hF); step();
    check("mmio_dma_gnt", obs_dg, 1'b1);
    check("mmio_mem_we", obs_mwe, 1'b0);
    idle(); step();
    check("mmio_dma_err", obs_err, 1'b1);
    check("mmio_leds_kept", leds, 32'd0);
    step();
    check("mmio_err_pulse", obs_err, 1'b0);
    cpu_drive(1, 1, 4'hF, F3_WORD, MMIO, 32'hF); step();
    idle(); step();
    check("mmio_leds_cpu", leds, 32'hF);
    // DMA read from MMIO returns zero data.
    dma_drive(1, 0, 4'hF, F3_WORD, MMIO, 32'd0); step();
    idle(); step();
    check("mmio_rd_rv", obs_drv, 1'b1);
    check("mmio_rd_zero", obs_drd, 32'd0);

    // Sub-word pass-through: DMA SB, then CPU LB of the same byte.
    dma_drive(1, 1, 4'b1000, F3_BYTE, 32'h203, 32'h8000_0000); step();
    dma_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
    cpu_drive(1, 0, 4'hF, F3_BYTE, 32'h203, 32'd0); step();
    idle(); step();
    check("sb_lb_rv", obs_crv, 1'b1);
    check("sb_lb_rd", obs_crd, 32'hFFFF_FF80);

    // Reset arriving while a CPU read is in flight discards it.
    cpu_drive(1, 0, 4'hF, F3_WORD, 32'h100, 32'd0); step();
    check("midrd_accept", obs_cg, 1'b1);
    idle(); rst_n = 1'b0; step();
    check("midrd_rv_rst", obs_crv, 1'b0);
    rst_n = 1'b1; step();
    check("midrd_rv_after", obs_crv, 1'b0);

    // Random traffic; each port holds its request until the model says granted.
    for (int c = 0; c < 800; c++) begin
      if (!cpu_req || eg_c) begin
        if ($urandom_range(0, 3) != 0)
          cpu_drive(1, 1'($urandom_range(0, 1)), 4'hF, F3_WORD,
                    32'($urandom_range(0, 31)) << 2, $urandom);
        else
          cpu_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
      end
      if (!dma_req || eg_d) begin
        if ($urandom_range(0, 2) != 0)
          dma_drive(1, 1'($urandom_range(0, 1)), 4'hF, F3_WORD,
                    (($urandom_range(0, 5) == 0) ? MMIO : 32'd0) |
                    (32'($urandom_range(0, 31)) << 2), $urandom);
        else
          dma_drive(0, 0, 4'h0, F3_WORD, 32'd0, 32'd0);
      end
      step();
    end
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
